// File: rtl/mux_cfg_pkg.sv
// Shared definitions for the configurable N-level routing mux: FSM states,
// clog2 and config-width derivation. Optional parity: MUX_CFG_PARITY_EN.
package mux_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ARMED = 2'd2
  } mux_state_e;

`ifdef MUX_CFG_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  function automatic int cfg_bits(input int num_levels, input int basis_size);
    return num_levels * basis_size;
  endfunction

  // The parity bit, when built, is the last bit shifted in and sits in chain[0].
  function automatic int chain_len(input int num_levels, input int basis_size);
    return cfg_bits(num_levels, basis_size) + (PARITY_EN ? 1 : 0);
  endfunction

endpackage

// File: rtl/mux_cfg_onehot_chk.sv
// Legality check for one level field: flags exactly-one-hot and returns the
// binary branch index of the set bit.
module mux_cfg_onehot_chk
  import mux_cfg_pkg::*;
#(
  parameter int BASIS_SIZE = 4,
  parameter int IDX_W      = (clog2(BASIS_SIZE) < 1) ? 1 : clog2(BASIS_SIZE)
) (
  input  logic [BASIS_SIZE-1:0] i_field,
  output logic                  o_onehot,
  output logic [IDX_W-1:0]      o_idx
);

  int w_ones;

  always_comb begin
    w_ones = 0;
    o_idx  = '0;
    for (int k = 0; k < BASIS_SIZE; k++) begin
      if (i_field[k]) begin
        w_ones = w_ones + 1;
        o_idx  = o_idx | IDX_W'(k);
      end
    end
    o_onehot = (w_ones == 1);
  end

endmodule

// File: rtl/mux_nlevel_cfg.sv
// N-input multi-level one-hot routing mux with serial config chain, commit
// validation and a sticky reject flag. Optional parity: MUX_CFG_PARITY_EN.
module mux_nlevel_cfg
  import mux_cfg_pkg::*;
#(
  parameter int NUM_INPUTS = 16,
  parameter int BASIS_SIZE = 4,
  parameter int NUM_LEVELS = 2
) (
  input  logic                  prog_clk,
  input  logic                  prog_reset_n,
  input  logic                  ccff_head,
  output logic                  ccff_tail,
  input  logic                  cfg_en,
  input  logic                  cfg_commit,
  input  logic [NUM_INPUTS-1:0] in,
  output logic                  out,
  output logic                  cfg_valid,
  output logic                  cfg_err,
  output logic [1:0]            dbg_state
);

  localparam int CFG_BITS = cfg_bits(NUM_LEVELS, BASIS_SIZE);
  localparam int CHAIN    = chain_len(NUM_LEVELS, BASIS_SIZE);
  localparam int CNT_W    = clog2(CHAIN + 1);
  localparam int LIDX_W   = (clog2(BASIS_SIZE) < 1) ? 1 : clog2(BASIS_SIZE);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CHAIN);

  logic [CHAIN-1:0]      r_chain;
  logic [CFG_BITS-1:0]   r_active;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_n;
  mux_state_e            r_state;
  mux_state_e            w_state_n;
  logic                  r_cfg_valid;
  logic                  r_cfg_err;

  logic [CFG_BITS-1:0]   w_cfg;
  logic [NUM_LEVELS-1:0] w_oh;
  logic [LIDX_W-1:0]     w_lidx [NUM_LEVELS];
  int                    w_sh_idx;
  int                    w_act_idx;
  logic                  w_all_oh;
  logic                  w_par_ok;
  logic                  w_accept;
  logic [NUM_INPUTS-1:0] w_sel;

  // Config bits are the oldest CFG_BITS bits of the chain; the first bit
  // shifted in ends up as the MSB of the top level field.
  assign w_cfg = r_chain[CHAIN-1 -: CFG_BITS];

  for (genvar g = 0; g < NUM_LEVELS; g++) begin : g_lvl
    mux_cfg_onehot_chk #(
      .BASIS_SIZE (BASIS_SIZE)
    ) u_chk (
      .i_field  (w_cfg[g*BASIS_SIZE +: BASIS_SIZE]),
      .o_onehot (w_oh[g]),
      .o_idx    (w_lidx[g])
    );
  end

  always_comb begin
    w_sh_idx = 0;
    for (int l = 0; l < NUM_LEVELS; l++) begin
      w_sh_idx = w_sh_idx + int'(w_lidx[l]) * (BASIS_SIZE ** l);
    end
  end

  assign w_all_oh = &w_oh;

`ifdef MUX_CFG_PARITY_EN
  assign w_par_ok = ^r_chain;
`else
  assign w_par_ok = 1'b1;
`endif

  // A commit that coincides with a shift is always rejected.
  assign w_accept = cfg_commit && !cfg_en && (r_state == ARMED) &&
                    w_all_oh && (w_sh_idx < NUM_INPUTS) && w_par_ok;

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    if (cfg_en) begin
      w_cnt_n   = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
      w_state_n = (w_cnt_n == CNT_MAX) ? ARMED : SHIFT;
    end else if (cfg_commit) begin
      w_state_n = IDLE;
      w_cnt_n   = '0;
    end
  end

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      r_chain     <= '0;
      r_active    <= '0;
      r_cnt       <= '0;
      r_state     <= IDLE;
      r_cfg_valid <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      if (cfg_en) begin
        r_chain <= {r_chain[CHAIN-2:0], ccff_head};
      end
      if (cfg_commit) begin
        if (w_accept) begin
          r_active    <= w_cfg;
          r_cfg_valid <= 1'b1;
          r_cfg_err   <= 1'b0;
        end else begin
          r_cfg_err   <= 1'b1;
        end
      end
    end
  end

  // Active config only ever holds a legal pattern, so summing set bits
  // yields the one selected index.
  always_comb begin
    w_act_idx = 0;
    for (int l = 0; l < NUM_LEVELS; l++) begin
      for (int k = 0; k < BASIS_SIZE; k++) begin
        if (r_active[l*BASIS_SIZE + k]) begin
          w_act_idx = w_act_idx + k * (BASIS_SIZE ** l);
        end
      end
    end
  end

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      w_sel[i] = (w_act_idx == i);
    end
  end

  assign out       = r_cfg_valid & (|(in & w_sel));
  assign ccff_tail = r_chain[CHAIN-1];
  assign cfg_valid = r_cfg_valid;
  assign cfg_err   = r_cfg_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mux_nlevel_cfg.sv
// Directed bench for mux_nlevel_cfg: default 16-input instance plus a
// 10-input instance for the index range check.
module tb_mux_nlevel_cfg;
  import mux_cfg_pkg::*;

  localparam int CFG_BITS = cfg_bits(2, 4);
  localparam int CHAIN    = chain_len(2, 4);

  logic        clk;
  logic        rst_n;
  logic        head;
  logic        en;
  logic        commit;
  logic [15:0] in_v;
  logic        tail, out_v, valid, err;
  logic [1:0]  state;
  logic        tail10, out10, valid10, err10;
  logic [1:0]  state10;

  int n_checks = 0;
  int n_errors = 0;

  mux_nlevel_cfg dut (
    .prog_clk     (clk),
    .prog_reset_n (rst_n),
    .ccff_head    (head),
    .ccff_tail    (tail),
    .cfg_en       (en),
    .cfg_commit   (commit),
    .in           (in_v),
    .out          (out_v),
    .cfg_valid    (valid),
    .cfg_err      (err),
    .dbg_state    (state)
  );

  mux_nlevel_cfg #(.NUM_INPUTS(10)) dut10 (
    .prog_clk     (clk),
    .prog_reset_n (rst_n),
    .ccff_head    (head),
    .ccff_tail    (tail10),
    .cfg_en       (en),
    .cfg_commit   (commit),
    .in           (in_v[9:0]),
    .out          (out10),
    .cfg_valid    (valid10),
    .cfg_err      (err10),
    .dbg_state    (state10)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // drivers
  task automatic shift_bit(input logic b);
    en   = 1'b1;
    head = b;
    @(posedge clk);
    #1;
    en   = 1'b0;
    head = 1'b0;
  endtask

  task automatic load_cfg(input logic [CFG_BITS-1:0] cfg);
    for (int i = CFG_BITS - 1; i >= 0; i--) shift_bit(cfg[i]);
`ifdef MUX_CFG_PARITY_EN
    shift_bit(~^cfg);
`endif
  endtask

  task automatic do_commit();
    commit = 1'b1;
    @(posedge clk);
    #1;
    commit = 1'b0;
  endtask

  initial begin
    rst_n  = 1'b0;
    head   = 1'b0;
    en     = 1'b0;
    commit = 1'b0;
    in_v   = 16'hFFFF;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", valid, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_out", out_v, 0);
    check_eq("rst_tail", tail, 0);
    check_eq("rst_state", state, 0);
    rst_n = 1'b1;

    // select in[9]: level1=0100, level0=0010
    load_cfg(8'b0100_0010);
    check_eq("armed_state", state, 2);
    check_eq("pre_commit_valid", valid, 0);
    do_commit();
    check_eq("in9_valid", valid, 1);
    check_eq("in9_err", err, 0);
    check_eq("in9_state_idle", state, 0);
    check_eq("in9_valid10", valid10, 1);
    in_v = 16'h0200; #1;
    check_eq("in9_out_hi", out_v, 1);
    in_v = 16'hFDFF; #1;
    check_eq("in9_out_lo", out_v, 0);
    in_v = 16'h0100; #1;
    check_eq("in9_neighbor", out_v, 0);

    // illegal level1 field (two bits set)
    load_cfg(8'b0110_0010);
    do_commit();
    check_eq("illegal_err", err, 1);
    check_eq("illegal_valid", valid, 1);
    in_v = 16'h0200; #1;
    check_eq("illegal_out_hi", out_v, 1);
    in_v = 16'hFDFF; #1;
    check_eq("illegal_out_lo", out_v, 0);

    // short shift then commit
    for (int i = 0; i < 5; i++) shift_bit(i[0]);
    check_eq("short_state", state, 1);
    do_commit();
    check_eq("short_err", err, 1);
    check_eq("short_valid", valid, 1);
    check_eq("short_state_idle", state, 0);
    in_v = 16'h0200; #1;
    check_eq("short_out", out_v, 1);

    // full reload to in[3]; out keeps old selection until commit
    load_cfg(8'b0001_1000);
    check_eq("shift_old_out", out_v, 1);
    do_commit();
    check_eq("in3_err_clear", err, 0);
    check_eq("in3_valid", valid, 1);
    in_v = 16'h0200; #1;
    check_eq("in3_old_gone", out_v, 0);
    in_v = 16'h0008; #1;
    check_eq("in3_out_hi", out_v, 1);
    in_v = 16'hFFF7; #1;
    check_eq("in3_out_lo", out_v, 0);

    // index 13: legal for 16 inputs, out of range for 10 inputs
    load_cfg(8'b1000_0010);
    do_commit();
    check_eq("idx13_err", err, 0);
    check_eq("idx13_err10", err10, 1);
    check_eq("idx13_valid10", valid10, 1);
    in_v = 16'h2000; #1;
    check_eq("idx13_out", out_v, 1);
    check_eq("idx13_out10", out10, 0);
    in_v = 16'h0008; #1;
    check_eq("idx13_out10_old", out10, 1);
    check_eq("idx13_out_lo", out_v, 0);

    // commit together with shift: rejected, shift still applies
    load_cfg(8'b0100_0010);
    en     = 1'b1;
    commit = 1'b1;
    head   = 1'b0;
    @(posedge clk);
    #1;
    en     = 1'b0;
    commit = 1'b0;
    check_eq("both_err", err, 1);
    check_eq("both_state", state, 2);
    in_v = 16'h2000; #1;
    check_eq("both_out", out_v, 1);

    // over-shift keeps the last CHAIN bits
    load_cfg(8'b0100_0010);
    check_eq("over_state", state, 2);
    do_commit();
    check_eq("over_err", err, 0);
    in_v = 16'h0200; #1;
    check_eq("over_out", out_v, 1);

    // chain tail: flush zeros, then a single 1
    for (int i = 0; i < CHAIN; i++) shift_bit(1'b0);
    check_eq("flush_tail", tail, 0);
    for (int k = 1; k <= CHAIN + 1; k++) begin
      shift_bit(k == 1);
      check_eq($sformatf("tail_k%0d", k), tail, (k == CHAIN) ? 1 : 0);
    end

    // asynchronous reset in the middle of a shift sequence
    load_cfg('1);
    for (int i = 0; i < 4; i++) shift_bit(1'b1);
    check_eq("pre_rst_tail", tail, 1);
    check_eq("pre_rst_valid", valid, 1);
    in_v = 16'hFFFF;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_valid", valid, 0);
    check_eq("arst_err", err, 0);
    check_eq("arst_out", out_v, 0);
    check_eq("arst_tail", tail, 0);
    check_eq("arst_state", state, 0);
    #1;
    rst_n = 1'b1;
    do_commit();
    check_eq("post_rst_err", err, 1);
    check_eq("post_rst_valid", valid, 0);

`ifdef MUX_CFG_PARITY_EN
    // parity bit flipped: even overall parity must be rejected
    for (int i = CFG_BITS - 1; i >= 0; i--) shift_bit(i == 6 || i == 1);
    shift_bit(1'b0);
    do_commit();
    check_eq("par_bad_err", err, 1);
    check_eq("par_bad_valid", valid, 0);
    for (int i = CFG_BITS - 1; i >= 0; i--) shift_bit(i == 6 || i == 1);
    shift_bit(1'b1);
    do_commit();
    check_eq("par_ok_err", err, 0);
    check_eq("par_ok_valid", valid, 1);
    in_v = 16'h0200; #1;
    check_eq("par_ok_out", out_v, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
